// File: rtl/dram4464_pkg.sv
// Shared types and default constants for the 64K x 4 DRAM strobe responder.
package dram4464_pkg;

  localparam int ROW_COL_W       = 8;
  localparam int DATA_W          = 4;
  localparam int DEF_T_RAS_MIN   = 3;
  localparam int DEF_T_RP_MIN    = 2;
  localparam int DEF_REFRESH_MAX = 1000;

  typedef enum logic [2:0] {
    IDLE,
    ROW_OPEN,
    ACCESS,
    CBR_PEND,
    CBR
  } dram_state_t;

endpackage

// File: rtl/dram4464_if.sv
// DRAM pin bundle: strobes, multiplexed address and split data bus.
interface dram4464_if;
  import dram4464_pkg::*;

  logic [ROW_COL_W-1:0] ram_addr;
  logic                 ram_ras_;
  logic                 ram_cas_;
  logic                 ram_we_;
  logic                 ram_oe_;
  logic [DATA_W-1:0]    ram_dq_in;
  logic [DATA_W-1:0]    ram_dq_out;
  logic                 ram_dq_oe;

  modport master (
    output ram_addr, ram_ras_, ram_cas_, ram_we_, ram_oe_, ram_dq_in,
    input  ram_dq_out, ram_dq_oe
  );

  modport slave (
    input  ram_addr, ram_ras_, ram_cas_, ram_we_, ram_oe_, ram_dq_in,
    output ram_dq_out, ram_dq_oe
  );

endinterface

// File: rtl/dram4464_store.sv
// Simple dual-port synchronous storage with a registered read port.
module dram4464_store
  import dram4464_pkg::*;
#(
  parameter int ABITS = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ABITS-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ABITS-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ABITS)-1];
  logic [DATA_W-1:0] rd_data_q;

  // No reset here so the array and read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dram4464_responder.sv
// Device-side responder for the 4464 strobe protocol with timing and refresh checks.
module dram4464_responder
  import dram4464_pkg::*;
#(
  parameter int MEM_ABITS   = 12,
  parameter int T_RAS_MIN   = DEF_T_RAS_MIN,
  parameter int T_RP_MIN    = DEF_T_RP_MIN,
  parameter int REFRESH_MAX = DEF_REFRESH_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  dram4464_if.slave   bus,
  input  logic        err_clr,
  output logic        refresh_err,
  output logic        timing_err,
  output logic [15:0] cbr_count
);

  localparam logic [7:0]  RAS_MIN_C = 8'(T_RAS_MIN);
  localparam logic [7:0]  RP_MIN_C  = 8'(T_RP_MIN);
  localparam logic [15:0] WD_MAX    = 16'(REFRESH_MAX);

  logic [ROW_COL_W-1:0] addr_q, addr_d, row_q, row_d;
  logic [DATA_W-1:0]    dq_in_q, dq_in_d, dq_out_q, dq_out_d;
  logic                 ras_q, ras_d, cas_q, cas_d, we_q, we_d, oe_q, oe_d;
  logic                 ras_prev_q, ras_prev_d, cas_prev_q, cas_prev_d;
  dram_state_t          state_q, state_d;
  logic                 is_read_q, is_read_d, rd_pend_q, rd_pend_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [7:0]           ras_cnt_q, ras_cnt_d;
  logic                 rose_seen_q, rose_seen_d;
  logic                 wd_armed_q, wd_armed_d;
  logic [15:0]          wd_cnt_q, wd_cnt_d, cbr_count_q, cbr_count_d;
  logic                 refresh_err_q, refresh_err_d, timing_err_q, timing_err_d;

  logic                 ras_fall, ras_rise, cas_fall, cas_rise;
  logic                 wr_en, rd_en, cbr_start, tim_viol, ref_viol;
  logic [MEM_ABITS-1:0] mem_idx;
  logic [DATA_W-1:0]    rd_data;

  assign ras_fall = ras_prev_q & ~ras_q;
  assign ras_rise = ~ras_prev_q & ras_q;
  assign cas_fall = cas_prev_q & ~cas_q;
  assign cas_rise = ~cas_prev_q & cas_q;
  assign mem_idx  = MEM_ABITS'({row_q, addr_q});

  dram4464_store #(.ABITS(MEM_ABITS)) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (mem_idx),
    .wr_data (dq_in_q),
    .rd_en   (rd_en),
    .rd_addr (mem_idx),
    .rd_data (rd_data)
  );

  // Next-state decode: strobe edges drive the FSM, timing checks and refresh watchdog.
  always_comb begin
    addr_d      = bus.ram_addr;
    dq_in_d     = bus.ram_dq_in;
    ras_d       = bus.ram_ras_;
    cas_d       = bus.ram_cas_;
    we_d        = bus.ram_we_;
    oe_d        = bus.ram_oe_;
    ras_prev_d  = ras_q;
    cas_prev_d  = cas_q;
    state_d     = state_q;
    row_d       = row_q;
    is_read_d   = is_read_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    cbr_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ras_fall) begin
          if (cas_q) begin
            row_d   = addr_q;
            state_d = ROW_OPEN;
          end else begin
            state_d   = CBR;
            cbr_start = 1'b1;
          end
        end else if (cas_fall && ras_q) begin
          state_d = CBR_PEND;
        end
      end
      ROW_OPEN: begin
        if (ras_rise) begin
          state_d = IDLE;
        end else if (cas_fall) begin
          state_d   = ACCESS;
          is_read_d = we_q;
          wr_en     = ~we_q;
          rd_en     = we_q;
        end
      end
      ACCESS: begin
        if (ras_rise)      state_d = IDLE;
        else if (cas_rise) state_d = ROW_OPEN;
      end
      CBR_PEND: begin
        if (ras_fall) begin
          state_d   = CBR;
          cbr_start = 1'b1;
        end else if (cas_rise) begin
          state_d = IDLE;
        end
      end
      CBR: begin
        if (ras_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_pend_d = rd_en;
    dq_out_d  = rd_pend_q ? rd_data : dq_out_q;
    dq_oe_d   = (state_q == ACCESS) & is_read_q & ~cas_q & ~oe_q & ~ras_q;

    ras_cnt_d   = (ras_fall || ras_rise) ? 8'd1 :
                  (ras_cnt_q == 8'hFF) ? ras_cnt_q : ras_cnt_q + 8'd1;
    rose_seen_d = rose_seen_q | ras_rise;
    tim_viol    = (ras_rise && (ras_cnt_q < RAS_MIN_C)) ||
                  (ras_fall && rose_seen_q && (ras_cnt_q < RP_MIN_C));

    wd_armed_d = wd_armed_q | cbr_start;
    wd_cnt_d   = wd_cnt_q;
    ref_viol   = 1'b0;
    if (cbr_start) begin
      wd_cnt_d = 16'd0;
    end else if (wd_armed_q && (wd_cnt_q != WD_MAX)) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
      ref_viol = (wd_cnt_d == WD_MAX);
    end

    cbr_count_d   = (cbr_start && (cbr_count_q != 16'hFFFF)) ? cbr_count_q + 16'd1 : cbr_count_q;
    timing_err_d  = (timing_err_q & ~err_clr) | tim_viol;
    refresh_err_d = (refresh_err_q & ~err_clr) | ref_viol;
  end

  // All responder state, with asynchronous return to reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      dq_in_q       <= '0;
      ras_q         <= 1'b1;
      cas_q         <= 1'b1;
      we_q          <= 1'b1;
      oe_q          <= 1'b1;
      ras_prev_q    <= 1'b1;
      cas_prev_q    <= 1'b1;
      state_q       <= IDLE;
      row_q         <= '0;
      is_read_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      dq_out_q      <= '0;
      dq_oe_q       <= 1'b0;
      ras_cnt_q     <= '0;
      rose_seen_q   <= 1'b0;
      wd_armed_q    <= 1'b0;
      wd_cnt_q      <= '0;
      cbr_count_q   <= '0;
      timing_err_q  <= 1'b0;
      refresh_err_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      dq_in_q       <= dq_in_d;
      ras_q         <= ras_d;
      cas_q         <= cas_d;
      we_q          <= we_d;
      oe_q          <= oe_d;
      ras_prev_q    <= ras_prev_d;
      cas_prev_q    <= cas_prev_d;
      state_q       <= state_d;
      row_q         <= row_d;
      is_read_q     <= is_read_d;
      rd_pend_q     <= rd_pend_d;
      dq_out_q      <= dq_out_d;
      dq_oe_q       <= dq_oe_d;
      ras_cnt_q     <= ras_cnt_d;
      rose_seen_q   <= rose_seen_d;
      wd_armed_q    <= wd_armed_d;
      wd_cnt_q      <= wd_cnt_d;
      cbr_count_q   <= cbr_count_d;
      timing_err_q  <= timing_err_d;
      refresh_err_q <= refresh_err_d;
    end
  end

  assign bus.ram_dq_out = dq_out_q;
  assign bus.ram_dq_oe  = dq_oe_q;
  assign refresh_err    = refresh_err_q;
  assign timing_err     = timing_err_q;
  assign cbr_count      = cbr_count_q;

endmodule

// File: tb/tb_dram4464_responder.sv
// Directed bench for dram4464_responder: CBR, read/write, page mode, timing and refresh checks.
module tb_dram4464_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_clr;
  logic        refresh_err;
  logic        timing_err;
  logic [15:0] cbr_count;
  logic        mid_oe;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  dram4464_if bus ();

  dram4464_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .err_clr     (err_clr),
    .refresh_err (refresh_err),
    .timing_err  (timing_err),
    .cbr_count   (cbr_count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ras, input logic cas, input logic we, input logic oe,
                               input logic [7:0] addr, input logic [3:0] dq);
    bus.ram_ras_   = ras;
    bus.ram_cas_   = cas;
    bus.ram_we_    = we;
    bus.ram_oe_    = oe;
    bus.ram_addr   = addr;
    bus.ram_dq_in  = dq;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CAS lead clock, RAS low 3 clocks, both high 3 clocks; OE held as given.
  task automatic applyCbr(input logic oe, output logic oe_seen);
    applyStimulus(1'b1, 1'b0, 1'b1, oe, 8'h00, 4'h0);
    cycle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, oe, 8'h00, 4'h0);
    cycle(3);
    oe_seen = bus.ram_dq_oe;
    applyStimulus(1'b1, 1'b1, 1'b1, oe, 8'h00, 4'h0);
    cycle(3);
  endtask

  // Single early-write cycle with RAS low 4 clocks and 3 clocks precharge.
  task automatic doWrite(input logic [7:0] row, input logic [7:0] col, input logic [3:0] d);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, row, 4'h0);
    cycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, col, d);
    cycle(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, col, 4'h0);
    cycle(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(3);
  endtask

  initial begin
    $display("[TB] start");
    rst_n   = 1'b0;
    err_clr = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(3);
    checkOutput("rst_dq_out",      16'(bus.ram_dq_out), 16'h0);
    checkOutput("rst_dq_oe",       16'(bus.ram_dq_oe),  16'h0);
    checkOutput("rst_refresh_err", 16'(refresh_err),    16'h0);
    checkOutput("rst_timing_err",  16'(timing_err),     16'h0);
    checkOutput("rst_cbr_count",   cbr_count,           16'h0);
    rst_n = 1'b1;
    cycle(2);

    // Eight CBR refreshes with OE held low; output drive must never turn on.
    for (int i = 0; i < 8; i++) begin
      applyCbr(1'b0, mid_oe);
      checkOutput($sformatf("cbr_mid_oe_%0d", i), 16'(mid_oe), 16'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(1);
    checkOutput("cbr_count_8",    cbr_count,        16'd8);
    checkOutput("cbr_timing_err", 16'(timing_err),  16'h0);
    checkOutput("cbr_refresh_err",16'(refresh_err), 16'h0);
    checkOutput("cbr_dq_oe",      16'(bus.ram_dq_oe), 16'h0);

    // Early write then read back with OE low, tracking drive-enable timing.
    doWrite(8'h12, 8'h34, 4'hA);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 4'h0);
    cycle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h34, 4'h0);
    cycle(1);
    checkOutput("rd_oe_clk0", 16'(bus.ram_dq_oe), 16'h0);
    cycle(1);
    checkOutput("rd_oe_clk1", 16'(bus.ram_dq_oe), 16'h0);
    cycle(1);
    checkOutput("rd_oe_clk2", 16'(bus.ram_dq_oe), 16'h1);
    checkOutput("rd_data",    16'(bus.ram_dq_out), 16'hA);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h34, 4'h0);
    cycle(1);
    checkOutput("rd_oe_cas_hi0", 16'(bus.ram_dq_oe), 16'h1);
    cycle(1);
    checkOutput("rd_oe_cas_hi1", 16'(bus.ram_dq_oe), 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(3);

    // Page mode: one RAS low, four writes then four reads of row 0.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'(c), 4'(5 + c));
      cycle(1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'(c), 4'h0);
      cycle(1);
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(c), 4'h0);
      cycle(3);
      checkOutput($sformatf("page_rd_%0d", c), 16'(bus.ram_dq_out), 16'(5 + c));
      checkOutput($sformatf("page_oe_%0d", c), 16'(bus.ram_dq_oe),  16'h1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'(c), 4'h0);
      cycle(1);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(3);
    checkOutput("page_timing_err", 16'(timing_err), 16'h0);

    // RAS low only 2 clocks.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(3);
    checkOutput("tras_short", 16'(timing_err), 16'h1);
    err_clr = 1'b1;
    cycle(1);
    err_clr = 1'b0;
    checkOutput("tras_clr", 16'(timing_err), 16'h0);

    // RAS high only 1 clock between two legal low periods.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(3);
    checkOutput("trp_short", 16'(timing_err), 16'h1);
    err_clr = 1'b1;
    cycle(1);
    err_clr = 1'b0;
    checkOutput("trp_clr", 16'(timing_err), 16'h0);

    // Aliasing: row 0x11 maps onto row 0x01 with 12 stored address bits.
    doWrite(8'h01, 8'h00, 4'h3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 4'h0);
    cycle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    cycle(3);
    checkOutput("alias_rd",    16'(bus.ram_dq_out), 16'h3);
    checkOutput("alias_oe_on", 16'(bus.ram_dq_oe),  16'h1);

    // Reset asserted mid-read, away from the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_oe",  16'(bus.ram_dq_oe),  16'h0);
    checkOutput("midrst_out", 16'(bus.ram_dq_out), 16'h0);
    checkOutput("midrst_cbr", cbr_count,           16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0);
    cycle(2);
    rst_n = 1'b1;
    cycle(2);

    // One CBR, then starve the watchdog past its limit.
    applyCbr(1'b1, mid_oe);
    cycle(980);
    checkOutput("wd_before_limit", 16'(refresh_err), 16'h0);
    cycle(40);
    checkOutput("wd_after_limit",  16'(refresh_err), 16'h1);
    err_clr = 1'b1;
    cycle(1);
    err_clr = 1'b0;
    checkOutput("wd_clr", 16'(refresh_err), 16'h0);

    // Refresh every 781 clocks keeps the watchdog satisfied.
    for (int i = 0; i < 4; i++) begin
      applyCbr(1'b1, mid_oe);
      cycle(774);
    end
    checkOutput("wd_regular",      16'(refresh_err), 16'h0);
    checkOutput("wd_cbr_count",    cbr_count,        16'd5);
    checkOutput("wd_timing_err",   16'(timing_err),  16'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dram4464_responder.md
Name: dram4464_responder

Overview:
Synthesizable responder for the 64K x 4 multiplexed-address DRAM strobe protocol: RAS_/CAS_/WE_/OE_ plus an 8-bit row/column address and a 4-bit data bus. It decodes strobes sampled on clk and serves early-write, read, page-mode and CAS-before-RAS refresh cycles from on-chip block RAM. It sits on the device side of the DRAM pins so the controller can run on-chip, and it also serves as a protocol checker: it flags refresh starvation and RAS timing violations.

Parameters:
MEM_ABITS, 12, stored address bits; the storage index is {row,col}[MEM_ABITS-1:0], so higher addresses alias.
T_RAS_MIN, 3, minimum clocks RAS_ held low.
T_RP_MIN, 2, minimum clocks RAS_ held high (precharge) between RAS-low periods.
REFRESH_MAX, 1000, maximum clocks allowed between CBR refreshes once the watchdog is armed.

Ports:
clk  in  1  system clock; all strobes are synchronous to it
rst_n  in  1  asynchronous active-low reset
ram_addr  in  8  multiplexed row/column address
ram_ras_  in  1  row strobe, active low
ram_cas_  in  1  column strobe, active low
ram_we_  in  1  write enable, active low
ram_oe_  in  1  output enable, active low
ram_dq_in  in  4  write data from the controller
ram_dq_out  out  4  read data
ram_dq_oe  out  1  read-data drive enable for the tri-state pad
err_clr  in  1  synchronous clear of the sticky error flags
refresh_err  out  1  sticky: refresh interval exceeded
timing_err  out  1  sticky: T_RAS_MIN or T_RP_MIN violated
cbr_count  out  16  saturating count of CBR refreshes

Behaviour:
- Reset values: ram_dq_out=0, ram_dq_oe=0, refresh_err=0, timing_err=0, cbr_count=0, state=IDLE, watchdog disarmed, previous-strobe registers all 1. Memory contents are not cleared.
- Inputs are registered once. Edge = registered value differs from the previous registered value. All decisions use the registered copies.
- FSM states: IDLE, ROW_OPEN, ACCESS, CBR_PEND, CBR.
- IDLE:
  - RAS_ falls while CAS_ is high: latch row=ram_addr, go to ROW_OPEN.
  - CAS_ falls while RAS_ is high: go to CBR_PEND.
- ROW_OPEN:
  - CAS_ falls: latch col=ram_addr, go to ACCESS.
  - If WE_ is low in that cycle: mem[idx] <= ram_dq_in (early write).
  - Otherwise: issue a read.
- ACCESS:
  - Read data appears on ram_dq_out 2 cycles after the CAS_ fall is sampled.
  - ram_dq_oe = read cycle & CAS_ low & OE_ low, registered. It deasserts the cycle after CAS_ or OE_ is sampled high.
  - CAS_ rises: back to ROW_OPEN. Page mode is supported; each new CAS_ fall latches a fresh column.
- RAS_ rises in ROW_OPEN or ACCESS: go to IDLE, ram_dq_oe <= 0.
  - If RAS_-low duration < T_RAS_MIN: timing_err <= 1.
- CBR_PEND:
  - RAS_ falls: go to CBR. cbr_count++ (saturates at 0xFFFF), watchdog counter <= 0, watchdog armed.
  - CAS_ rises first: back to IDLE, no error.
- CBR: no memory access; WE_ and OE_ are ignored. RAS_ rises: go to IDLE, with the T_RAS_MIN check applied.
- Precharge check: when RAS_ falls, if the RAS_-high duration since the last rise < T_RP_MIN, set timing_err. The first RAS_ fall after reset is exempt.
- Refresh watchdog:
  - Counts every clock while armed.
  - Reaching REFRESH_MAX sets refresh_err and holds the count.
  - Disarmed at reset; armed by the first CBR.
- err_clr clears both sticky flags. If err_clr coincides with a new error, the error wins.
- Strobes moving together:
  - RAS_ and CAS_ both fall in the same sample from IDLE: treated as CBR.
  - RAS_ rising while CAS_ is low ends the access. A subsequent CAS_ rise in IDLE is ignored.
- rst_n asserted mid-cycle: immediate return to reset values. A write in progress in that same cycle is not guaranteed.

Decomposition:
- Package dram4464_pkg holds:
  - state enum dram_state_t;
  - default timing constants: T_RAS_MIN=3, T_RP_MIN=2, REFRESH_MAX=1000;
  - row/column width constant of 8.
- One sub-module, dram4464_store: simple dual-port synchronous RAM, 2**MEM_ABITS x 4, registered read. It infers block RAM.

Test Plan:
- Reset, then 8 CBR cycles (CAS_ low, RAS_ low 3 clocks, both high 3 clocks) -> cbr_count=8, no errors, ram_dq_oe stays 0.
- Early write row 0x12 col 0x34 data 0xA, then read the same address with OE_ low -> ram_dq_out=0xA, ram_dq_oe=1 from the 2nd clock after CAS_ is sampled low, 0 the clock after CAS_ is sampled high.
- Page mode: one RAS_ low, writes cols 0x00..0x03 with data 5,6,7,8, then page read of the same cols -> 5,6,7,8, timing_err=0.
- RAS_ low for only 2 clocks -> timing_err=1; err_clr pulse -> 0. RAS_ high for only 1 clock between cycles -> timing_err=1.
- One CBR, then no refresh for 1000 clocks -> refresh_err=1 at the count; with a CBR every 781 clocks -> refresh_err stays 0.
- Aliasing with MEM_ABITS=12: write 0x3 at row 0x01 col 0x00, read row 0x11 col 0x00 -> 0x3. Assert rst_n mid-read -> ram_dq_oe=0 immediately.
